// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, controller
// states and default operation latencies.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic int unsigned cnt_width(input int unsigned m, input int unsigned d);
        return $clog2(((m > d) ? m : d) + 1);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the issuing pipeline (master) and the MDU (slave).
interface mdu_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, output op, output a, output b,
                    input  busy,  input  hi, input  lo);

    modport slave  (input  start, input  op, input  a, input  b,
                    output busy,  output hi, output lo);

endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers: the result is computed
// at the accepting edge and held pending until the busy countdown expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_state_e       state_q   = ST_IDLE;
    logic [CNT_W-1:0] cnt_q     = '0;
    logic [31:0]      hi_q      = '0;
    logic [31:0]      lo_q      = '0;
    logic [31:0]      pend_hi_q = '0;
    logic [31:0]      pend_lo_q = '0;

    logic [31:0] pend_hi_d, pend_lo_d;
    mdu_op_e     op;
    logic        is_signed, a_neg, b_neg;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] div_a, div_b, uq, ur;

    // One unsigned multiplier and divider serve both signednesses: signed
    // multiply uses sign-extended operands, signed divide works on magnitudes.
    always_comb begin
        op        = mdu_op_e'(bus.op);
        is_signed = (op == OP_MULT) || (op == OP_DIV);

        mul_a   = is_signed ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
        mul_b   = is_signed ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
        product = mul_a * mul_b;

        a_neg = is_signed & bus.a[31];
        b_neg = is_signed & bus.b[31];
        div_a = a_neg ? (32'd0 - bus.a) : bus.a;
        div_b = b_neg ? (32'd0 - bus.b) : bus.b;
        uq    = '0;
        ur    = '0;
        if (div_b != '0) begin
            uq = div_a / div_b;
            ur = div_a % div_b;
        end

        pend_hi_d = hi_q;
        pend_lo_d = lo_q;
        case (op)
            OP_MULT, OP_MULTU: {pend_hi_d, pend_lo_d} = product;
            OP_DIV, OP_DIVU: begin
                if (div_b != '0) begin
                    pend_lo_d = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
                    pend_hi_d = a_neg ? (32'd0 - ur) : ur;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_q <= pend_hi_d;
                                pend_lo_q <= pend_lo_d;
                                cnt_q     <= CNT_W'(MULT_CYCLES);
                                state_q   <= ST_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_q <= pend_hi_d;
                                pend_lo_q <= pend_lo_d;
                                cnt_q     <= CNT_W'(DIV_CYCLES);
                                state_q   <= ST_BUSY;
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q == ST_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a cycle-level reference model built on 64-bit integer
// arithmetic is compared every cycle, plus literal expectations per scenario.
module tb_mdu;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mdu_if bus ();

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    longint      sa, sb, ua, ub, res;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (bus.start) begin
            sa = $signed(bus.a);
            sb = $signed(bus.b);
            ua = bus.a;
            ub = bus.b;
            case (bus.op)
                3'd1: begin res = sa * sb; p_hi = res[63:32]; p_lo = res[31:0]; m_left = 5; end
                3'd2: begin res = ua * ub; p_hi = res[63:32]; p_lo = res[31:0]; m_left = 5; end
                3'd3: begin
                    p_hi = m_hi; p_lo = m_lo;
                    if (sb != 0) begin
                        res = sa / sb; p_lo = res[31:0];
                        res = sa % sb; p_hi = res[31:0];
                    end
                    m_left = 10;
                end
                3'd4: begin
                    p_hi = m_hi; p_lo = m_lo;
                    if (ub != 0) begin
                        res = ua / ub; p_lo = res[31:0];
                        res = ua % ub; p_hi = res[31:0];
                    end
                    m_left = 10;
                end
                3'd5: m_hi = bus.a;
                3'd6: m_lo = bus.a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if (bus.busy !== (m_left > 0) || bus.hi !== m_hi || bus.lo !== m_lo) begin
            n_fail++;
            $display("FAIL model busy/hi/lo at %0t: got %b/%h/%h want %b/%h/%h",
                     $time, bus.busy, bus.hi, bus.lo, (m_left > 0), m_hi, m_lo);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    int c;

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(c);
        check("mult busy cycles", c, 32'd5);
        check("mult hi", bus.hi, 32'hFFFF_FFFF);
        check("mult lo", bus.lo, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(c);
        check("multu busy cycles", c, 32'd5);
        check("multu hi", bus.hi, 32'hFFFF_FFFE);
        check("multu lo", bus.lo, 32'h0000_0001);

        issue(3'd1, 32'h8000_0000, 32'd2);
        wait_idle(c);
        check("mult min*2 hi", bus.hi, 32'hFFFF_FFFF);
        check("mult min*2 lo", bus.lo, 32'h0);

        issue(3'd2, 32'h8000_0000, 32'd2);
        wait_idle(c);
        check("multu 2^31*2 hi", bus.hi, 32'h1);
        check("multu 2^31*2 lo", bus.lo, 32'h0);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(c);
        check("div busy cycles", c, 32'd10);
        check("div -7/2 lo", bus.lo, 32'hFFFF_FFFD);
        check("div -7/2 hi", bus.hi, 32'hFFFF_FFFF);

        issue(3'd4, 32'd7, 32'd0);
        wait_idle(c);
        check("divu by zero busy cycles", c, 32'd10);
        check("divu by zero hi", bus.hi, 32'hFFFF_FFFF);
        check("divu by zero lo", bus.lo, 32'hFFFF_FFFD);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(c);
        check("div overflow lo", bus.lo, 32'h8000_0000);
        check("div overflow hi", bus.hi, 32'h0);

        issue(3'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle(c);
        check("div 7/-2 lo", bus.lo, 32'hFFFF_FFFD);
        check("div 7/-2 hi", bus.hi, 32'h1);

        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle(c);
        check("divu big/2 lo", bus.lo, 32'h7FFF_FFFC);
        check("divu big/2 hi", bus.hi, 32'h1);

        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        check("mthi hi", bus.hi, 32'h1234_5678);
        check("mthi lo untouched", bus.lo, 32'h7FFF_FFFC);
        issue(3'd6, 32'hCAFE_BABE, 32'd0);
        check("mtlo lo", bus.lo, 32'hCAFE_BABE);

        issue(3'd0, 32'h1111_1111, 32'h2222_2222);
        issue(3'd7, 32'h3333_3333, 32'h4444_4444);
        check("nop busy", {31'd0, bus.busy}, 32'd0);
        check("nop hi", bus.hi, 32'h1234_5678);
        check("nop lo", bus.lo, 32'hCAFE_BABE);

        issue(3'd1, 32'd6, 32'd7);
        issue(3'd6, 32'hDEAD_0000, 32'd0);
        issue(3'd5, 32'hBEEF_0000, 32'd0);
        check("hold hi while busy", bus.hi, 32'h1234_5678);
        wait_idle(c);
        check("mtlo ignored lo", bus.lo, 32'd42);
        check("mthi ignored hi", bus.hi, 32'd0);

        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort hi", bus.hi, 32'h0);
        check("abort lo", bus.lo, 32'h0);
        repeat (15) @(negedge clk);
        check("no late commit hi", bus.hi, 32'h0);
        check("no late commit lo", bus.lo, 32'h0);

        issue(3'd1, 32'd3, 32'd5);
        bus.a = 32'd100;
        bus.b = 32'd100;
        wait_idle(c);
        check("operand hold cycles", c, 32'd5);
        check("operand hold lo", bus.lo, 32'd15);
        issue(3'd2, 32'd7, 32'd9);
        check("back-to-back busy", {31'd0, bus.busy}, 32'd1);
        wait_idle(c);
        check("back-to-back cycles", c, 32'd5);
        check("back-to-back lo", bus.lo, 32'd63);
        check("back-to-back hi", bus.hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
